m_stage_lsu: RTL and testbench

- Memory-stage load/store unit. Consumes the M-stage pipeline register outputs and runs a req/ack transaction to the data memory for lw/lh/lhu/lb/lbu/sw/sh/sb.
- Stalls the pipeline while the transaction is in flight, then drives the W-stage pipeline register with the instruction, the write address and the extended load result.
- Sits between the E→M register and the register-file writeback.

---
 rtl/m_stage_lsu.sv | 157 +++++++++++++++
 tb/tb_m_stage_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/m_stage_lsu.sv
// Memory-stage load/store unit: runs one req/ack data-memory transaction per
// load/store, stalls the pipeline meanwhile, and feeds the W-stage register.
module m_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_GRF_RD2,
  input  logic [4:0]  M_GRF_WA,
  input  logic [31:0] M_ALU_result,
  input  logic [1:0]  Tnew_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        M_stall,
  output logic        dm_timeout,
  output logic [31:0] W_instr,
  output logic [31:0] W_pc,
  output logic [4:0]  W_GRF_WA,
  output logic [31:0] W_result,
  output logic [1:0]  Tnew_W
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_buf;
  logic [5:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[{a, 3'b000} +: 8];
    case (op)
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  assign opcode   = M_instr[31:26];
  assign is_load  = (opcode == OP_LW) || (opcode == OP_LH) || (opcode == OP_LHU) ||
                    (opcode == OP_LB) || (opcode == OP_LBU);
  assign is_store = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
  assign mem_op   = is_load || is_store;

  // The stall must already be high in the IDLE cycle that launches the request.
  assign M_stall = (state == REQ) || ((state == IDLE) && mem_op);

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = M_GRF_RD2;
    case (opcode)
      OP_SW: store_be = 4'b1111;
      OP_SH: begin
        store_be    = M_ALU_result[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{M_GRF_RD2[15:0]}};
      end
      OP_SB: begin
        store_be    = 4'b0001 << M_ALU_result[1:0];
        store_wdata = {4{M_GRF_RD2[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      rdata_buf  <= 32'd0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'd0;
      dm_be      <= 4'b0000;
      dm_wdata   <= 32'd0;
      dm_timeout <= 1'b0;
      W_instr    <= 32'd0;
      W_pc       <= 32'd0;
      W_GRF_WA   <= 5'd0;
      W_result   <= 32'd0;
      Tnew_W     <= 2'd0;
    end else begin
      dm_timeout <= 1'b0;
      case (state)
        IDLE: if (mem_op) begin
          state    <= REQ;
          dm_req   <= 1'b1;
          dm_we    <= is_store;
          dm_addr  <= {M_ALU_result[31:2], 2'b00};
          dm_be    <= store_be;
          dm_wdata <= store_wdata;
          wait_cnt <= 8'd0;
        end
        REQ: begin
          // Ack beats the timeout when both land on the same cycle.
          if (dm_ack) begin
            dm_req    <= 1'b0;
            rdata_buf <= dm_rdata;
            state     <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            dm_req     <= 1'b0;
            rdata_buf  <= 32'd0;
            dm_timeout <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // W-stage register: bubble while stalled.
      if (M_stall) begin
        W_instr  <= 32'd0;
        W_pc     <= 32'd0;
        W_GRF_WA <= 5'd0;
        W_result <= 32'd0;
        Tnew_W   <= 2'd0;
      end else begin
        W_instr  <= M_instr;
        W_pc     <= M_pc;
        W_GRF_WA <= M_GRF_WA;
        W_result <= is_load ? load_extend(opcode, M_ALU_result[1:0], rdata_buf) : M_ALU_result;
        Tnew_W   <= (Tnew_M != 2'd0) ? Tnew_M - 2'd1 : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_m_stage_lsu.sv
// Randomized bench for m_stage_lsu: transactions are driven one at a time and
// every observable is compared against a transaction-level reference model.
module tb_m_stage_lsu;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_instr, M_pc, M_GRF_RD2, M_ALU_result;
  logic [4:0]  M_GRF_WA;
  logic [1:0]  Tnew_M;
  logic        dm_req, dm_we, dm_ack, M_stall, dm_timeout;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic [31:0] W_instr, W_pc, W_result;
  logic [4:0]  W_GRF_WA;
  logic [1:0]  Tnew_W;

  int tests = 0;
  int fails = 0;

  m_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .M_instr(M_instr), .M_pc(M_pc), .M_GRF_RD2(M_GRF_RD2),
    .M_GRF_WA(M_GRF_WA), .M_ALU_result(M_ALU_result), .Tnew_M(Tnew_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .M_stall(M_stall), .dm_timeout(dm_timeout),
    .W_instr(W_instr), .W_pc(W_pc), .W_GRF_WA(W_GRF_WA), .W_result(W_result), .Tnew_W(Tnew_W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory-op semantics expressed with plain arithmetic.
  function automatic bit mdl_is_load(input logic [5:0] op);
    return op inside {6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100};
  endfunction

  function automatic bit mdl_is_store(input logic [5:0] op);
    return op inside {6'b101011, 6'b101001, 6'b101000};
  endfunction

  function automatic logic [31:0] mdl_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] v;
    int k;
    k = int'(addr & 32'd3);
    case (op)
      6'b100001, 6'b100101: begin
        v = (w >> (16 * (k / 2))) & 32'hFFFF;
        if (op == 6'b100001 && v >= 32'h8000) v = v - 32'h10000;
      end
      6'b100000, 6'b100100: begin
        v = (w >> (8 * k)) & 32'hFF;
        if (op == 6'b100000 && v >= 32'h80) v = v - 32'h100;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mdl_be(input logic [5:0] op, input logic [31:0] addr);
    int k;
    k = int'(addr & 32'd3);
    case (op)
      6'b101011: return 32'hF;
      6'b101001: return 32'(3 << (2 * (k / 2)));
      6'b101000: return 32'(1 << k);
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [5:0] op, input logic [31:0] rd2);
    case (op)
      6'b101001: return (rd2 & 32'hFFFF) * 32'h00010001;
      6'b101000: return (rd2 & 32'hFF) * 32'h01010101;
      default:   return rd2;
    endcase
  endfunction

  // Drives one instruction from a post-edge point until it leaves M; ack_delay is
  // the number of REQ cycles without ack before ack (>= MAX_WAIT means never).
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rd2, input logic [4:0] wa,
                           input logic [31:0] alu, input logic [1:0] tn,
                           input int ack_delay, input logic [31:0] rdata);
    logic [5:0]  op;
    logic [31:0] exp_res;
    bit          done;
    bit          timed_out;
    op = instr[31:26];
    M_instr = instr; M_pc = pc; M_GRF_RD2 = rd2; M_GRF_WA = wa;
    M_ALU_result = alu; Tnew_M = tn;
    exp_res = alu;
    if (mdl_is_load(op) || mdl_is_store(op)) begin
      @(negedge clk);
      check("stall_idle", 32'(M_stall), 32'd1);
      check("req_idle", 32'(dm_req), 32'd0);
      @(posedge clk); #1;
      check("req_up", 32'(dm_req), 32'd1);
      check("we", 32'(dm_we), 32'(mdl_is_store(op)));
      check("addr", dm_addr, alu & 32'hFFFF_FFFC);
      check("be", 32'(dm_be), mdl_be(op, alu));
      if (mdl_is_store(op)) check("wdata", dm_wdata, mdl_wdata(op, rd2));
      check("bubble_instr", W_instr, 32'd0);
      done = 0;
      timed_out = 0;
      for (int i = 0; i < MAX_WAIT && !done && !timed_out; i++) begin
        dm_ack   = (i == ack_delay);
        dm_rdata = (i == ack_delay) ? rdata : $urandom;
        @(negedge clk);
        check("stall_req", 32'(M_stall), 32'd1);
        check("req_hold", 32'(dm_req), 32'd1);
        check("no_to_req", 32'(dm_timeout), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        if (i == ack_delay) done = 1;
        else if (i == MAX_WAIT - 1) timed_out = 1;
      end
      check("req_drop", 32'(dm_req), 32'd0);
      check("timeout", 32'(dm_timeout), 32'(timed_out));
      check("stall_done", 32'(M_stall), 32'd0);
      if (mdl_is_load(op)) exp_res = timed_out ? 32'd0 : mdl_load(op, alu, rdata);
    end else begin
      @(negedge clk);
      check("stall_alu", 32'(M_stall), 32'd0);
    end
    @(posedge clk); #1;
    check("w_instr", W_instr, instr);
    check("w_pc", W_pc, pc);
    check("w_wa", 32'(W_GRF_WA), 32'(wa));
    check("w_result", W_result, exp_res);
    check("tnew_w", 32'(Tnew_W), 32'((tn > 0) ? tn - 1 : 0));
    check("req_after", 32'(dm_req), 32'd0);
    check("to_after", 32'(dm_timeout), 32'd0);
  endtask

  initial begin
    logic [5:0]  ops[11];
    logic [5:0]  op;
    logic [31:0] a;
    ops = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100,
            6'b101011, 6'b101001, 6'b101000, 6'b000000, 6'b001101, 6'b001111};
    reset = 1'b0; dm_ack = 1'b0; dm_rdata = 32'd0;
    M_instr = 32'd0; M_pc = 32'd0; M_GRF_RD2 = 32'd0; M_GRF_WA = 5'd0;
    M_ALU_result = 32'd0; Tnew_M = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_w_instr", W_instr, 32'd0);
    check("rst_stall", 32'(M_stall), 32'd0);
    reset = 1'b1;

    // lb sign extension, ack in first REQ cycle
    run_instr({6'b100000, 26'h0123456}, 32'h400, 32'h0, 5'd8, 32'h13, 2'd1, 0, 32'h80FF1234);
    // sh upper half
    run_instr({6'b101001, 26'h0}, 32'h404, 32'hABCD1234, 5'd0, 32'h1006, 2'd0, 0, 32'h0);
    // back-to-back addu then lhu
    run_instr(32'h00851021, 32'h408, 32'h0, 5'd2, 32'h55AA, 2'd1, 0, 32'h0);
    run_instr({6'b100101, 26'h0}, 32'h40C, 32'h0, 5'd3, 32'h22, 2'd2, 0, 32'hBEEF0000);
    // timeout on a load, then a late ack seen in IDLE
    run_instr({6'b100011, 26'h0}, 32'h410, 32'h0, 5'd4, 32'h80, 2'd2, MAX_WAIT, 32'h0);
    dm_ack = 1'b1;
    run_instr(32'h00000021, 32'h414, 32'h0, 5'd5, 32'h77, 2'd3, 0, 32'h0);
    dm_ack = 1'b0;
    // ack on the last allowed REQ cycle
    run_instr({6'b100011, 26'h0}, 32'h418, 32'h0, 5'd6, 32'h84, 2'd2, MAX_WAIT - 1, 32'hCAFEF00D);

    // reset held for 2 cycles mid-REQ
    M_instr = {6'b100011, 26'h0}; M_ALU_result = 32'h90;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(dm_req), 32'd1);
    reset = 1'b0;
    M_instr = 32'h00000021; M_pc = 32'h500; M_GRF_WA = 5'd9; M_ALU_result = 32'h1234; Tnew_M = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_req", 32'(dm_req), 32'd0);
    check("mid_rst_stall", 32'(M_stall), 32'd0);
    check("mid_rst_w_instr", W_instr, 32'd0);
    check("mid_rst_w_pc", W_pc, 32'd0);
    check("mid_rst_w_result", W_result, 32'd0);
    check("mid_rst_tnew", 32'(Tnew_W), 32'd0);
    reset = 1'b1;
    dm_ack = 1'b1;
    run_instr(32'h00000021, 32'h504, 32'h0, 5'd10, 32'h4321, 2'd1, 0, 32'h0);
    dm_ack = 1'b0;

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 10)];
      a  = $urandom;
      run_instr({op, 26'($urandom)}, $urandom, $urandom, 5'($urandom), a, 2'($urandom),
                $urandom_range(0, MAX_WAIT + 1), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
